// File: rtl/bramsd.sv
// bramsd -- simple-dual-port block RAM with byte-lane write enables.
//
// One write port (we/waddr/wdata/wbe) and one independent read port
// (re/raddr -> rdata/rvalid) on a single clock. The memory array carries no
// reset, so it can map onto block RAM. A clearing sweep can zero every word
// after reset.
//
// Parameters
//   ADDR_      address width; depth is 2**ADDR_ words
//   DATA_      word width; must be a multiple of BYTES_
//   BYTES_     number of byte lanes (lane width DATA_/BYTES_)
//   READ_REG_  0: read latency 1, 1: extra output register (latency 2)
//   RDW_NEW_   1: a same-address read during a write returns the merged
//              new data; 0: it returns the old data
//   CLEAR_     1: zero all words after reset; 0: contents survive reset
//
// Ports
//   clk     clock, rising edge
//   rst     synchronous active-high reset
//   we      write enable
//   waddr   write address
//   wdata   write data
//   wbe     per-lane write enables
//   re      read enable
//   raddr   read address
//   rdata   read data; holds its value between completed reads
//   rvalid  one-cycle pulse when rdata carries a completed read
//   busy    clearing sweep in progress; we and re are ignored
module bramsd #(
  parameter int ADDR_     = 8,
  parameter int DATA_     = 8,
  parameter int BYTES_    = 1,
  parameter int READ_REG_ = 0,
  parameter int RDW_NEW_  = 1,
  parameter int CLEAR_    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_-1:0]  waddr,
  input  logic [DATA_-1:0]  wdata,
  input  logic [BYTES_-1:0] wbe,
  input  logic              re,
  input  logic [ADDR_-1:0]  raddr,
  output logic [DATA_-1:0]  rdata,
  output logic              rvalid,
  output logic              busy
);

  localparam int LANE_  = DATA_ / BYTES_;
  localparam int DEPTH_ = 1 << ADDR_;

  // ---------------------------------------------------------------------
  // Clearing sweep FSM
  // ---------------------------------------------------------------------
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [ADDR_-1:0] cnt_reg, cnt_next;
  logic             sweep_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= (CLEAR_ != 0) ? ST_CLEAR : ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sweep_we   = 1'b0;
    case (state_reg)
      ST_CLEAR: begin
        sweep_we = 1'b1;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == {ADDR_{1'b1}}) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_reg == ST_CLEAR);

  // User requests are dropped (not queued) while sweeping or in reset.
  logic user_we, user_re;
  assign user_we = we & ~busy & ~rst;
  assign user_re = re & ~busy & ~rst;

  // ---------------------------------------------------------------------
  // Memory array: single write port shared by the sweep and the user
  // ---------------------------------------------------------------------
  logic [DATA_-1:0]  mem [0:DEPTH_-1];
  logic [ADDR_-1:0]  mem_addr;
  logic [DATA_-1:0]  mem_din;
  logic [BYTES_-1:0] mem_lane_we;

  assign mem_addr    = busy ? cnt_reg : waddr;
  assign mem_din     = busy ? '0 : wdata;
  assign mem_lane_we = busy ? {BYTES_{sweep_we & ~rst}}
                            : (user_we ? wbe : '0);

  always_ff @(posedge clk) begin
    for (int i = 0; i < BYTES_; i++) begin
      if (mem_lane_we[i]) begin
        mem[mem_addr][i*LANE_ +: LANE_] <= mem_din[i*LANE_ +: LANE_];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read port. The raw RAM output register always sees the old contents;
  // a new-data collision is handled by registering the colliding lanes and
  // the write data beside it and merging after the RAM, so the array keeps
  // a plain registered read.
  // ---------------------------------------------------------------------
  logic [DATA_-1:0]  ram_q_reg;
  logic [DATA_-1:0]  byp_data_reg;
  logic [BYTES_-1:0] byp_mask_reg;
  logic [BYTES_-1:0] collide;
  logic              rv1_reg;
  logic [DATA_-1:0]  rd_merged;

  genvar gi;
  generate
    for (gi = 0; gi < BYTES_; gi++) begin : g_lane
      assign collide[gi] = (RDW_NEW_ != 0) && user_we && user_re &&
                           wbe[gi] && (waddr == raddr);
      assign rd_merged[gi*LANE_ +: LANE_] =
        byp_mask_reg[gi] ? byp_data_reg[gi*LANE_ +: LANE_]
                         : ram_q_reg[gi*LANE_ +: LANE_];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_q_reg    <= '0;
      byp_data_reg <= '0;
      byp_mask_reg <= '0;
      rv1_reg      <= 1'b0;
    end else begin
      rv1_reg <= user_re;
      // Only an accepted read updates the stage, so rdata holds otherwise.
      if (user_re) begin
        ram_q_reg    <= mem[raddr];
        byp_data_reg <= wdata;
        byp_mask_reg <= collide;
      end
    end
  end

  generate
    if (READ_REG_ != 0) begin : g_out_reg
      logic [DATA_-1:0] rd2_reg;
      logic             rv2_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          rd2_reg <= '0;
          rv2_reg <= 1'b0;
        end else begin
          rv2_reg <= rv1_reg;
          if (rv1_reg) begin
            rd2_reg <= rd_merged;
          end
        end
      end

      assign rdata  = rd2_reg;
      assign rvalid = rv2_reg;
    end else begin : g_out_direct
      assign rdata  = rd_merged;
      assign rvalid = rv1_reg;
    end
  endgenerate

endmodule

// File: tb/tb_bramsd.sv
// tb_bramsd -- directed self-checking bench for bramsd.
//
// Three instances share clock and stimulus:
//   u_a: READ_REG_=0, RDW_NEW_=1, CLEAR_=1
//   u_b: READ_REG_=1, RDW_NEW_=0, CLEAR_=1
//   u_c: READ_REG_=1, RDW_NEW_=1, CLEAR_=0
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_bramsd;

  logic        clk;
  logic        rst;
  logic        we;
  logic [3:0]  waddr;
  logic [15:0] wdata;
  logic [1:0]  wbe;
  logic        re;
  logic [3:0]  raddr;

  logic [15:0] rdata_a, rdata_b, rdata_c;
  logic        rvalid_a, rvalid_b, rvalid_c;
  logic        busy_a, busy_b, busy_c;

  int total = 0;
  int bad   = 0;

  bramsd #(.ADDR_(4), .DATA_(16), .BYTES_(2), .READ_REG_(0), .RDW_NEW_(1), .CLEAR_(1)) u_a (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .re(re), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a), .busy(busy_a)
  );

  bramsd #(.ADDR_(4), .DATA_(16), .BYTES_(2), .READ_REG_(1), .RDW_NEW_(0), .CLEAR_(1)) u_b (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .re(re), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b), .busy(busy_b)
  );

  bramsd #(.ADDR_(4), .DATA_(16), .BYTES_(2), .READ_REG_(1), .RDW_NEW_(1), .CLEAR_(0)) u_c (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .re(re), .raddr(raddr), .rdata(rdata_c), .rvalid(rvalid_c), .busy(busy_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    we = 1'b1; waddr = a; wdata = d; wbe = be;
    @(negedge clk);
    we = 1'b0; wbe = 2'b00;
    $display("write addr=%0d data=%h wbe=%b", a, d, be);
  endtask

  // Single read: u_a result one cycle later, u_b/u_c two cycles later.
  task automatic issue_read(input logic [3:0] a,
                            output logic [15:0] d0, output logic v0,
                            output logic [15:0] d1, output logic v1,
                            output logic [15:0] d2, output logic v2);
    re = 1'b1; raddr = a;
    @(negedge clk);
    re = 1'b0;
    d0 = rdata_a; v0 = rvalid_a;
    @(negedge clk);
    d1 = rdata_b; v1 = rvalid_b;
    d2 = rdata_c; v2 = rvalid_c;
    $display("read addr=%0d a=%h/%b b=%h/%b c=%h/%b", a, d0, v0, d1, v1, d2, v2);
  endtask

  // Runs a sweep (rst just released) while hammering we/re each cycle.
  task automatic run_sweep(output int n, output logic saw_rv);
    n = 0;
    saw_rv = 1'b0;
    while (busy_a && n < 40) begin
      we = 1'b1; wbe = 2'b11; wdata = 16'h5555; waddr = n[3:0];
      re = 1'b1; raddr = n[3:0];
      @(negedge clk);
      n++;
      saw_rv = saw_rv | rvalid_a | rvalid_b;
    end
    we = 1'b0; re = 1'b0; wbe = 2'b00;
    @(negedge clk);
    saw_rv = saw_rv | rvalid_a | rvalid_b;
    $display("sweep busy_cycles=%0d saw_rvalid=%b", n, saw_rv);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; we = 1'b0; re = 1'b0; waddr = '0; raddr = '0; wdata = '0; wbe = '0;
    repeat (2) @(negedge clk);
    total++; if (rdata_a !== 16'h0000) begin bad++; $display("FAIL reset_rdata_a got=%h want=0000", rdata_a); end
    total++; if (rdata_b !== 16'h0000) begin bad++; $display("FAIL reset_rdata_b got=%h want=0000", rdata_b); end
    total++; if (rvalid_a !== 1'b0) begin bad++; $display("FAIL reset_rvalid_a got=%b want=0", rvalid_a); end
    total++; if (rvalid_c !== 1'b0) begin bad++; $display("FAIL reset_rvalid_c got=%b want=0", rvalid_c); end
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL reset_busy_a got=%b want=1", busy_a); end
    total++; if (busy_b !== 1'b1) begin bad++; $display("FAIL reset_busy_b got=%b want=1", busy_b); end
    total++; if (busy_c !== 1'b0) begin bad++; $display("FAIL reset_busy_c got=%b want=0", busy_c); end
    $display("reset checked");
  endtask

  task automatic test_sweep();
    int n;
    logic saw;
    logic [3:0] a;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_sweep(n, saw);
    total++; if (n !== 16) begin bad++; $display("FAIL sweep1_len got=%0d want=16", n); end
    total++; if (saw !== 1'b0) begin bad++; $display("FAIL sweep1_rvalid got=%b want=0", saw); end
    for (int i = 0; i < 16; i++) begin
      a = 4'(i);
      do_write(a, 16'hFFFF, 2'b11);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_sweep(n, saw);
    total++; if (n !== 16) begin bad++; $display("FAIL sweep2_len got=%0d want=16", n); end
    total++; if (saw !== 1'b0) begin bad++; $display("FAIL sweep2_rvalid got=%b want=0", saw); end
    for (int i = 0; i <= 16; i++) begin
      re = (i < 16);
      raddr = 4'(i);
      @(negedge clk);
      if (i < 16) begin
        total++;
        if (rvalid_a !== 1'b1 || rdata_a !== 16'h0000) begin
          bad++; $display("FAIL sweep_zero_a addr=%0d got=%h/%b want=0000/1", i, rdata_a, rvalid_a);
        end
      end
      if (i >= 1) begin
        total++;
        if (rvalid_b !== 1'b1 || rdata_b !== 16'h0000) begin
          bad++; $display("FAIL sweep_zero_b addr=%0d got=%h/%b want=0000/1", i - 1, rdata_b, rvalid_b);
        end
      end
    end
    re = 1'b0;
    $display("sweep readback done");
  endtask

  task automatic test_byte_enable();
    logic [15:0] d0, d1, d2;
    logic v0, v1, v2;
    do_write(4'd3, 16'hABCD, 2'b11);
    do_write(4'd3, 16'h1200, 2'b10);
    issue_read(4'd3, d0, v0, d1, v1, d2, v2);
    total++; if (d0 !== 16'h12CD || v0 !== 1'b1) begin bad++; $display("FAIL be_a got=%h/%b want=12cd/1", d0, v0); end
    total++; if (d1 !== 16'h12CD || v1 !== 1'b1) begin bad++; $display("FAIL be_b got=%h/%b want=12cd/1", d1, v1); end
    total++; if (d2 !== 16'h12CD || v2 !== 1'b1) begin bad++; $display("FAIL be_c got=%h/%b want=12cd/1", d2, v2); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] da [5];
    logic [15:0] db [5];
    logic [15:0] dc [5];
    logic        va [5];
    logic        vb [5];
    logic        vc [5];
    logic        exp_va [5];
    logic        exp_vb [5];
    logic [15:0] exp_da [5];
    logic [15:0] exp_db [5];
    exp_va = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_vb = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_da = '{16'h0101, 16'h0202, 16'h0303, 16'h0303, 16'h0303};
    exp_db = '{16'h12CD, 16'h0101, 16'h0202, 16'h0303, 16'h0303};
    do_write(4'd1, 16'h0101, 2'b11);
    do_write(4'd2, 16'h0202, 2'b11);
    do_write(4'd3, 16'h0303, 2'b11);
    for (int i = 0; i < 5; i++) begin
      re = (i < 3);
      raddr = 4'(i + 1);
      @(negedge clk);
      da[i] = rdata_a; va[i] = rvalid_a;
      db[i] = rdata_b; vb[i] = rvalid_b;
      dc[i] = rdata_c; vc[i] = rvalid_c;
    end
    re = 1'b0;
    for (int i = 0; i < 5; i++) begin
      $display("stream cycle=%0d a=%h/%b b=%h/%b c=%h/%b", i + 1, da[i], va[i], db[i], vb[i], dc[i], vc[i]);
      total++;
      if (va[i] !== exp_va[i] || da[i] !== exp_da[i]) begin
        bad++; $display("FAIL b2b_a cycle=%0d got=%h/%b want=%h/%b", i + 1, da[i], va[i], exp_da[i], exp_va[i]);
      end
      total++;
      if (vb[i] !== exp_vb[i] || db[i] !== exp_db[i]) begin
        bad++; $display("FAIL b2b_b cycle=%0d got=%h/%b want=%h/%b", i + 1, db[i], vb[i], exp_db[i], exp_vb[i]);
      end
      total++;
      if (vc[i] !== exp_vb[i] || dc[i] !== exp_db[i]) begin
        bad++; $display("FAIL b2b_c cycle=%0d got=%h/%b want=%h/%b", i + 1, dc[i], vc[i], exp_db[i], exp_vb[i]);
      end
    end
  endtask

  task automatic test_collision();
    logic [15:0] d0, d1, d2;
    logic v0, v1, v2;
    do_write(4'd5, 16'h1111, 2'b11);
    we = 1'b1; waddr = 4'd5; wdata = 16'h22EE; wbe = 2'b01;
    re = 1'b1; raddr = 4'd5;
    @(negedge clk);
    we = 1'b0; re = 1'b0; wbe = 2'b00;
    $display("collision a=%h/%b", rdata_a, rvalid_a);
    total++; if (rdata_a !== 16'h11EE || rvalid_a !== 1'b1) begin bad++; $display("FAIL rdw_new_a got=%h/%b want=11ee/1", rdata_a, rvalid_a); end
    @(negedge clk);
    $display("collision b=%h/%b c=%h/%b", rdata_b, rvalid_b, rdata_c, rvalid_c);
    total++; if (rdata_b !== 16'h1111 || rvalid_b !== 1'b1) begin bad++; $display("FAIL rdw_old_b got=%h/%b want=1111/1", rdata_b, rvalid_b); end
    total++; if (rdata_c !== 16'h11EE || rvalid_c !== 1'b1) begin bad++; $display("FAIL rdw_new_c got=%h/%b want=11ee/1", rdata_c, rvalid_c); end
    issue_read(4'd5, d0, v0, d1, v1, d2, v2);
    total++; if (d0 !== 16'h11EE) begin bad++; $display("FAIL rdw_after_a got=%h want=11ee", d0); end
    total++; if (d1 !== 16'h11EE) begin bad++; $display("FAIL rdw_after_b got=%h want=11ee", d1); end
    total++; if (d2 !== 16'h11EE) begin bad++; $display("FAIL rdw_after_c got=%h want=11ee", d2); end
  endtask

  task automatic test_inflight_write();
    logic [15:0] d0, d1, d2;
    logic v0, v1, v2;
    re = 1'b1; raddr = 4'd5;
    @(negedge clk);
    re = 1'b0;
    we = 1'b1; waddr = 4'd5; wdata = 16'h3333; wbe = 2'b11;
    total++; if (rdata_a !== 16'h11EE) begin bad++; $display("FAIL inflight_a got=%h want=11ee", rdata_a); end
    @(negedge clk);
    we = 1'b0; wbe = 2'b00;
    $display("inflight b=%h/%b c=%h/%b", rdata_b, rvalid_b, rdata_c, rvalid_c);
    total++; if (rdata_b !== 16'h11EE || rvalid_b !== 1'b1) begin bad++; $display("FAIL inflight_b got=%h/%b want=11ee/1", rdata_b, rvalid_b); end
    total++; if (rdata_c !== 16'h11EE || rvalid_c !== 1'b1) begin bad++; $display("FAIL inflight_c got=%h/%b want=11ee/1", rdata_c, rvalid_c); end
    issue_read(4'd5, d0, v0, d1, v1, d2, v2);
    total++; if (d1 !== 16'h3333 || v1 !== 1'b1) begin bad++; $display("FAIL inflight_after_b got=%h/%b want=3333/1", d1, v1); end
  endtask

  task automatic test_reset_midflight();
    logic [15:0] d0, d1, d2;
    logic v0, v1, v2;
    int n;
    re = 1'b1; raddr = 4'd5;
    @(negedge clk);
    re = 1'b0; rst = 1'b1;
    @(negedge clk);
    $display("reset in flight b=%b c=%b", rvalid_b, rvalid_c);
    total++; if (rvalid_b !== 1'b0) begin bad++; $display("FAIL midflight_b got=%b want=0", rvalid_b); end
    total++; if (rvalid_c !== 1'b0) begin bad++; $display("FAIL midflight_c got=%b want=0", rvalid_c); end
    rst = 1'b0;
    repeat (7) @(negedge clk);
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL midsweep_busy got=%b want=1", busy_a); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (busy_a && n < 40) begin
      @(negedge clk);
      n++;
    end
    $display("restarted sweep busy_cycles=%0d", n);
    total++; if (n !== 16) begin bad++; $display("FAIL restart_len got=%0d want=16", n); end
    total++; if (busy_c !== 1'b0) begin bad++; $display("FAIL noclear_busy_c got=%b want=0", busy_c); end
    issue_read(4'd5, d0, v0, d1, v1, d2, v2);
    total++; if (d0 !== 16'h0000 || v0 !== 1'b1) begin bad++; $display("FAIL restart_clear_a got=%h/%b want=0000/1", d0, v0); end
    total++; if (d2 !== 16'h3333 || v2 !== 1'b1) begin bad++; $display("FAIL survive_c got=%h/%b want=3333/1", d2, v2); end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_byte_enable();
    test_back_to_back();
    test_collision();
    test_inflight_write();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bramsd.md
# bramsd

Parametrised simple-dual-port block RAM: one write port with byte enables and one independent read port on a single clock. It is the successor to the single-port `brams` block and is inferred from behavioural RAM, not a vendor primitive. It adds an optional read output register, a selectable read-during-write policy and a post-reset clearing sweep. It sits under register files, FIFOs and scratchpads that need a concurrent read and write every cycle.

## Interface
- ADDR_, 8, address width; depth is 2**ADDR_ words
- DATA_, 8, word width in bits; must be a multiple of BYTES_
- BYTES_, 1, number of byte lanes; lane width is DATA_/BYTES_
- READ_REG_, 0, 0: read latency 1; 1: extra output register, read latency 2
- RDW_NEW_, 1, 1: a same-address read during a write returns the new data (byte-merged); 0: returns the old data
- CLEAR_, 1, 1: zero all words after reset; 0: no sweep, contents untouched by reset
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset; synchronous, active-high; clears control and output state, and starts the sweep when CLEAR_=1
- we  in  1  write enable
- waddr  in  ADDR_  write address
- wdata  in  DATA_  write data
- wbe  in  BYTES_  byte-lane write enables; a lane is written only when we=1 and its wbe bit is 1
- re  in  1  read enable
- raddr  in  ADDR_  read address
- rdata  out  DATA_  read data; holds its last value when no read completes
- rvalid  out  1  one-cycle pulse marking the cycle in which rdata carries a completed read
- busy  out  1  clear sweep in progress; the RAM ignores we and re while busy=1

## Operation
- Reset values: rdata=0 and rvalid=0. busy=1 when CLEAR_=1, else 0. The sweep counter is set to 0. All pipeline valid bits are cleared.
- Clear sweep (CLEAR_=1) uses two states, CLEAR and IDLE.
  - rst puts the block in CLEAR with the counter at 0.
  - Each rising edge with rst=0 in CLEAR writes all lanes of word[counter] to 0, then increments the counter.
  - After writing word 2**ADDR_-1, the block moves to IDLE and busy falls.
  - A reset asserted mid-sweep restarts the sweep at word 0.
- While busy=1:
  - we and re are dropped entirely, not queued.
  - rvalid stays 0.
  - No user write reaches the memory.
- Write: when we=1 and busy=0, lane i of mem[waddr] takes wdata lane i for every i with wbe[i]=1. Other lanes are unchanged. we=1 with wbe=0 is a no-op.
- Read: when re=1 and busy=0, mem[raddr] is sampled on that edge.
  - The value is presented after the latency given under Timing, with rvalid=1 for exactly one cycle.
  - Back-to-back reads stream one result per cycle.
- Read-during-write collision (re=1, we=1, raddr=waddr, same edge):
  - RDW_NEW_=1: lanes with wbe set return wdata; all other lanes return the stored value.
  - RDW_NEW_=0: every lane returns the value stored before the write.
  - In both modes the write always completes.
- A write to an address that already has a read in flight (already sampled) does not alter that read's result.
- Reset during an in-flight read discards the read: no rvalid is issued for it.
- Memory contents are unaffected by rst when CLEAR_=0.

## Timing
- READ_REG_=0: read accepted at edge t; rdata and rvalid are valid after edge t, i.e. in cycle t+1.
- READ_REG_=1: read accepted at edge t; rdata and rvalid are valid in cycle t+2.
- A write at edge t is visible to a non-colliding read accepted at edge t+1 or later.
- Sweep duration is exactly 2**ADDR_ cycles from the first edge with rst=0. busy is 0 in the cycle after the last clearing edge. The first read or write accepted is at that edge.
- Throughput: one write and one read per cycle, with no stalls outside the sweep.

## Test plan
- Sweep (ADDR_=4, DATA_=16, BYTES_=2, CLEAR_=1), with memory preloaded with 0xFFFF:
  - Release rst, then count cycles: busy must stay high for exactly 16 cycles.
  - Then read all 16 addresses: every word must read 0x0000.
  - During the sweep, issue re=1 and we=1: no rvalid may appear and memory must be unchanged.
- Byte enables: write 0xABCD with wbe=11 to address 3, then write 0x1200 with wbe=10 to address 3. A read of address 3 must return 0x12CD.
- Latency: back-to-back reads of addresses 1, 2 and 3, holding 0x0101, 0x0202 and 0x0303.
  - READ_REG_=0: results must appear in consecutive cycles t+1, t+2 and t+3, with rvalid high for 3 cycles.
  - READ_REG_=1: the same results must appear in cycles t+2, t+3 and t+4.
- Collision: address 5 holds 0x1111. Write 0x22EE with wbe=01 and read address 5 on the same edge.
  - RDW_NEW_=1: the read must return 0x11EE.
  - RDW_NEW_=0: the read must return 0x1111.
  - In both modes a later read must return 0x11EE.
- Reset mid-operation, with READ_REG_=1:
  - Issue a read, then assert rst on the next edge: no rvalid may follow.
  - With CLEAR_=1, assert rst at sweep count 7: busy must stay high for 16 further cycles after release.
  - With CLEAR_=0, assert rst: previously written data must survive.
